mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the data-memory port. It sits between the pipeline MEM stage and the word-wide data memory. It accepts one load/store request at a time over a valid/ready handshake and drives the memory's address, write-data, MemWrite and MemRead lines. Sub-word stores are performed as read-modify-write, and sub-word loads are extracted and sign- or zero-extended. It returns exactly one response per request.

## Interface
- `DATA_W`, default 32: data and address width; fixed at 32 in this design.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit can accept a request; high only in IDLE.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed_i`  in  1  sign-extend a sub-word load.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_rdata_o`  out  32  load result; 0 for stores and errors.
- `rsp_err_o`  out  1  misaligned or illegal-size request.
- `mem_addr_o`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `mem_wdata_o`  out  32  full word to write.
- `mem_write_o`  out  1  MemWrite.
- `mem_read_o`  out  1  MemRead.
- `mem_rdata_i`  in  32  word read from memory.

## Operation
- Byte order is little-endian. Lane k is bits [8k+7:8k] and holds the byte at word address + k.
- Request fields are captured on the accept edge (`req_valid_i & req_ready_o`). Inputs are ignored after that edge.
- Misalignment is an error: half with addr[0]=1, word with addr[1:0]≠0, or size 11. An erroneous request makes no memory access and gives a response with err=1 and rdata=0.
- States:
  - IDLE: ready=1. On accept:
    - error request → RESP.
    - load → READ.
    - word store → WRITE.
    - byte/half store → RMW_READ.
  - READ: mem_read_o=1. mem_rdata_i is latched at the end of the cycle. Then → RESP.
  - WRITE: mem_write_o=1, mem_wdata_o = store data. Then → RESP.
  - RMW_READ: mem_read_o=1. Latch the word, then → RMW_WRITE.
  - RMW_WRITE: mem_write_o=1. mem_wdata_o is the latched word with only the addressed lane(s) replaced by the store data. Then → RESP.
  - RESP: rsp_valid_o=1 for exactly one cycle, then → IDLE.
- Load extraction:
  - byte: lane addr[1:0].
  - half: lanes addr[1]*2 and +1.
  - Extension: req_signed_i=1 sign-extends, otherwise zero-extends. Word loads are returned unmodified.
- mem_read_o and mem_write_o are never high together.
- Outside READ/WRITE/RMW states, mem_addr_o, mem_wdata_o, mem_read_o and mem_write_o are all 0.
- rsp_rdata_o and rsp_err_o are valid only while rsp_valid_o=1, and are 0 otherwise.

## Timing
- Reset (rst_i=0, asynchronous): state IDLE, req_ready_o=1, every other output 0, internal latches cleared.
- Reset mid-operation: abandon the request immediately. No further mem_write_o pulse and no response. A write that was asserted in the cycle reset falls is not guaranteed.
- Latency is counted from the accept edge (cycle 0) to the cycle in which rsp_valid_o is high:
  - error: cycle 1.
  - load / word store: cycle 2.
  - byte/half store: cycle 3.
- req_ready_o goes low the cycle after the accept edge and returns to 1 the cycle after RESP. Maximum throughput is one request every 3 cycles (word) or 4 cycles (RMW).
- The memory is assumed to present mem_rdata_i combinationally within the cycle mem_read_o is high. Writes are committed on the rising edge that ends the mem_write_o cycle.
- Each mem_read_o and mem_write_o assertion is exactly one cycle, with address and data stable for the whole cycle.
- req_valid_i held high across a response causes the next request to be accepted on the first IDLE edge.

## Test plan
- Preload bytes 0–4 = 03,05,00,07,15; load word, addr 0 → response at cycle 2 with rdata=0x07000503, err=0, one mem_read pulse, no mem_write.
- Store byte 0x80 at addr 5, then load byte addr 5 signed → 0xFFFFFF80. Same load unsigned → 0x00000080. Memory bytes 4, 6, 7 are unchanged.
- Store half 0xBEEF at addr 2 → mem_read in cycle 1, mem_write in cycle 2 with wdata 0xBEEF0503, response at cycle 3. A word load at addr 0 then returns 0xBEEF0503.
- Load word at addr 2, and separately size=11 at addr 0 → each gives a response at cycle 1 with err=1, rdata=0, and no mem_read or mem_write pulse.
- Byte store accepted, rst_i pulled low during RMW_READ → outputs 0 immediately and no mem_write pulse. After release, ready=1 and memory is unchanged.
- Two loads with req_valid_i held high → accepts at cycles 0 and 3, responses at cycles 2 and 5, ready low in cycles 1–2.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory signal bundle for mem_access_unit
//
// Request side : req_valid_i/req_ready_o handshake, req_write_i, req_size_i,
//                req_signed_i, req_addr_i, req_wdata_i
// Response side: rsp_valid_o pulse with rsp_rdata_o and rsp_err_o
// Memory side  : mem_addr_o, mem_wdata_o, mem_write_o, mem_read_o, mem_rdata_i
// The _i/_o suffixes are from the unit's point of view.
// modport slave  : the access unit itself
// modport master : the pipeline stage and the data memory around it

interface mem_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [1:0]        req_size_i;
    logic              req_signed_i;
    logic [DATA_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;

    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_write_o;
    logic              mem_read_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_write_i, req_size_i, req_signed_i,
               req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mem_addr_o, mem_wdata_o, mem_write_o, mem_read_o
    );

    modport master (
        output req_valid_i, req_write_i, req_size_i, req_signed_i,
               req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mem_addr_o, mem_wdata_o, mem_write_o, mem_read_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a word-wide data memory
//
// Accepts one load/store at a time, performs sub-word stores as
// read-modify-write, extracts and extends sub-word loads, and returns
// exactly one response per request.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - mem_access_unit_if.slave: request handshake, response pulse,
//            and the memory address/data/MemRead/MemWrite lines
// Little-endian: lane k = bits [8k+7:8k] = byte at word address + k.

module mem_access_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    mem_access_unit_if.slave      bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_RMW_READ  = 3'd3;
    localparam logic [2:0] S_RMW_WRITE = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]        state;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              err_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic              req_err;

    logic [3:0]        lane_mask;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] store_rep;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;

    assign accept = bus.req_valid_i && (state == S_IDLE);

    // Misaligned or illegal-size requests never touch memory.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_size_i)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = bus.req_addr_i[0];
            SZ_WORD: req_err = |bus.req_addr_i[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        write_q  <= bus.req_write_i;
                        size_q   <= bus.req_size_i;
                        signed_q <= bus.req_signed_i;
                        addr_q   <= bus.req_addr_i;
                        wdata_q  <= bus.req_wdata_i;
                        err_q    <= req_err;
                        if (req_err)
                            state <= S_RESP;
                        else if (!bus.req_write_i)
                            state <= S_READ;
                        else if (bus.req_size_i == SZ_WORD)
                            state <= S_WRITE;
                        else
                            state <= S_RMW_READ;
                    end
                end
                S_READ: begin
                    rdata_q <= bus.mem_rdata_i;
                    state   <= S_RESP;
                end
                S_WRITE: begin
                    state <= S_RESP;
                end
                S_RMW_READ: begin
                    rdata_q <= bus.mem_rdata_i;
                    state   <= S_RMW_WRITE;
                end
                S_RMW_WRITE: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Store merge: replicate the store data across all lanes, then let the
    // lane mask pick which lanes of the latched word get overwritten.
    always_comb begin
        lane_mask = 4'b0000;
        store_rep = '0;
        if (size_q == SZ_BYTE) begin
            lane_mask = 4'b0001 << addr_q[1:0];
            store_rep = {4{wdata_q[7:0]}};
        end else begin
            lane_mask = 4'b0011 << {addr_q[1], 1'b0};
            store_rep = {2{wdata_q[15:0]}};
        end
        for (int i = 0; i < 4; i++) begin
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
        merged = (rdata_q & ~bit_mask) | (store_rep & bit_mask);
    end

    // Load extraction: shift the addressed lane(s) down to bit 0, then extend.
    always_comb begin
        shifted   = rdata_q >> {addr_q[1:0], 3'b000};
        load_data = rdata_q;
        case (size_q)
            SZ_BYTE: load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_data = rdata_q;
        endcase
    end

    logic mem_active;
    assign mem_active = (state == S_READ) || (state == S_WRITE) ||
                        (state == S_RMW_READ) || (state == S_RMW_WRITE);

    assign bus.req_ready_o = (state == S_IDLE);
    assign bus.mem_read_o  = (state == S_READ) || (state == S_RMW_READ);
    assign bus.mem_write_o = (state == S_WRITE) || (state == S_RMW_WRITE);
    assign bus.mem_addr_o  = mem_active ? {addr_q[DATA_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata_o = (state == S_WRITE)     ? wdata_q :
                             (state == S_RMW_WRITE) ? merged  : '0;

    assign bus.rsp_valid_o = (state == S_RESP);
    assign bus.rsp_err_o   = (state == S_RESP) && err_q;
    assign bus.rsp_rdata_o = ((state == S_RESP) && !err_q && !write_q) ? load_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit

module tb_mem_access_unit;

    logic clk;
    logic rst_n;

    mem_access_unit_if #(.DATA_W(32)) bus ();

    mem_access_unit #(.DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed data memory: combinational read, write on rising edge.
    logic [7:0] mem [0:63];
    logic [5:0] ma0, ma1, ma2, ma3;
    assign ma0 = {bus.mem_addr_o[5:2], 2'd0};
    assign ma1 = {bus.mem_addr_o[5:2], 2'd1};
    assign ma2 = {bus.mem_addr_o[5:2], 2'd2};
    assign ma3 = {bus.mem_addr_o[5:2], 2'd3};
    assign bus.mem_rdata_i = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};

    always @(posedge clk) begin
        if (bus.mem_write_o) begin
            mem[ma0] <= bus.mem_wdata_o[7:0];
            mem[ma1] <= bus.mem_wdata_o[15:8];
            mem[ma2] <= bus.mem_wdata_o[23:16];
            mem[ma3] <= bus.mem_wdata_o[31:24];
        end
    end

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Results of the last run_req
    int          r_lat, r_nrd, r_nwr, r_rdcyc, r_wrcyc;
    logic [31:0] r_rdata, r_wdata, r_waddr;
    logic        r_err;

    // Issue one request, scramble the inputs right after the accept edge,
    // and observe cycles 1..8 after it (cycle n follows the n-th edge).
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req_write_i  = w;
        bus.req_size_i   = sz;
        bus.req_signed_i = sg;
        bus.req_addr_i   = a;
        bus.req_wdata_i  = wd;
        bus.req_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = ~w;
        bus.req_size_i   = ~sz;
        bus.req_signed_i = ~sg;
        bus.req_addr_i   = 32'hDEAD_BEE0;
        bus.req_wdata_i  = 32'h5A5A_5A5A;
        r_lat = -1; r_nrd = 0; r_nwr = 0; r_rdcyc = -1; r_wrcyc = -1;
        r_rdata = 32'hX; r_wdata = 32'h0; r_waddr = 32'h0; r_err = 1'bX;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_read_o) begin
                r_nrd++;
                r_rdcyc = c;
            end
            if (bus.mem_write_o) begin
                r_nwr++;
                r_wrcyc = c;
                r_wdata = bus.mem_wdata_o;
                r_waddr = bus.mem_addr_o;
            end
            if (bus.rsp_valid_o) begin
                r_lat   = c;
                r_rdata = bus.rsp_rdata_o;
                r_err   = bus.rsp_err_o;
                break;
            end
        end
    endtask

    int   nw, nr;
    logic [7:0] rdy_pat, rsp_pat;
    logic [31:0] rsp_data [0:1];
    int   nresp;

    initial begin
        rst_n = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'b0;
        bus.req_size_i   = 2'b00;
        bus.req_signed_i = 1'b0;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        mem[0] <= 8'h03; mem[1] <= 8'h05; mem[2] <= 8'h00; mem[3] <= 8'h07;
        mem[4] <= 8'h15; mem[6] <= 8'h66; mem[7] <= 8'h77;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
        check("rst_flags", {28'b0, bus.rsp_valid_o, bus.rsp_err_o, bus.mem_read_o, bus.mem_write_o}, 32'd0);
        check("rst_addr_wdata", bus.mem_addr_o | bus.mem_wdata_o, 32'd0);
        check("rst_rdata", bus.rsp_rdata_o, 32'd0);
        rst_n = 1'b1;

        // Word load at 0
        run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check("lw0_lat", r_lat, 32'd2);
        check("lw0_rdata", r_rdata, 32'h0700_0503);
        check("lw0_err", {31'b0, r_err}, 32'd0);
        check("lw0_nrd", r_nrd, 32'd1);
        check("lw0_nwr", r_nwr, 32'd0);

        // Idle outputs quiet
        @(negedge clk);
        check("idle_ready", {31'b0, bus.req_ready_o}, 32'd1);
        check("idle_flags", {28'b0, bus.rsp_valid_o, bus.rsp_err_o, bus.mem_read_o, bus.mem_write_o}, 32'd0);
        check("idle_buses", bus.mem_addr_o | bus.mem_wdata_o | bus.rsp_rdata_o, 32'd0);

        // Byte store 0x80 at 5
        run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFF_FF80);
        check("sb5_lat", r_lat, 32'd3);
        check("sb5_rdcyc", r_rdcyc, 32'd1);
        check("sb5_wrcyc", r_wrcyc, 32'd2);
        check("sb5_wdata", r_wdata, 32'h7766_8015);
        check("sb5_waddr", r_waddr, 32'h4);
        check("sb5_rdata", r_rdata, 32'h0);
        run_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        check("lb5_signed", r_rdata, 32'hFFFF_FF80);
        check("lb5_lat", r_lat, 32'd2);
        run_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        check("lb5_unsigned", r_rdata, 32'h0000_0080);
        check("sb5_neighbours", {8'h0, mem[7], mem[6], mem[4]}, 32'h0077_6615);

        // Half store 0xBEEF at 2
        run_req(1'b1, 2'b01, 1'b0, 32'h2, 32'h1234_BEEF);
        check("sh2_rdcyc", r_rdcyc, 32'd1);
        check("sh2_wrcyc", r_wrcyc, 32'd2);
        check("sh2_wdata", r_wdata, 32'hBEEF_0503);
        check("sh2_lat", r_lat, 32'd3);
        run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check("lw0_after_sh", r_rdata, 32'hBEEF_0503);
        run_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        check("lh2_signed", r_rdata, 32'hFFFF_BEEF);
        run_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        check("lh2_unsigned", r_rdata, 32'h0000_BEEF);
        run_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
        check("lb3_unsigned", r_rdata, 32'h0000_00BE);

        // Word store at 8
        run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678);
        check("sw8_lat", r_lat, 32'd2);
        check("sw8_mem", {r_nrd[15:0], r_nwr[15:0]}, 32'h0000_0001);
        check("sw8_wdata", r_wdata, 32'h1234_5678);
        check("sw8_bytes", {16'h0, mem[11], mem[8]}, 32'h0000_1278);

        // Error requests
        run_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
        check("err_lw2_lat", r_lat, 32'd1);
        check("err_lw2_err", {31'b0, r_err}, 32'd1);
        check("err_lw2_rdata", r_rdata, 32'd0);
        check("err_lw2_mem", r_nrd + r_nwr, 32'd0);
        run_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        check("err_sz3_lat", r_lat, 32'd1);
        check("err_sz3_err", {31'b0, r_err}, 32'd1);
        check("err_sz3_rdata", r_rdata, 32'd0);
        check("err_sz3_mem", r_nrd + r_nwr, 32'd0);
        run_req(1'b1, 2'b01, 1'b0, 32'h1, 32'hFFFF);
        check("err_sh1_err", {31'b0, r_err}, 32'd1);
        check("err_sh1_mem", r_nrd + r_nwr, 32'd0);

        // Reset during RMW_READ of a byte store at 12
        @(negedge clk);
        bus.req_write_i  = 1'b1;
        bus.req_size_i   = 2'b00;
        bus.req_signed_i = 1'b0;
        bus.req_addr_i   = 32'hC;
        bus.req_wdata_i  = 32'hAA;
        bus.req_valid_i  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("rst_mid_rd", {31'b0, bus.mem_read_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {28'b0, bus.rsp_valid_o, bus.rsp_err_o, bus.mem_read_o, bus.mem_write_o}, 32'd0);
        check("rst_mid_addr", bus.mem_addr_o | bus.mem_wdata_o, 32'd0);
        check("rst_mid_ready", {31'b0, bus.req_ready_o}, 32'd1);
        nw = 0; nr = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (bus.mem_write_o) nw++;
            if (bus.rsp_valid_o) nr++;
        end
        check("rst_mid_nowrite", nw, 32'd0);
        check("rst_mid_noresp", nr, 32'd0);
        check("rst_mid_ready_after", {31'b0, bus.req_ready_o}, 32'd1);
        check("rst_mid_mem", {mem[15], mem[14], mem[13], mem[12]}, 32'd0);

        // Back-to-back loads with valid held high
        @(negedge clk);
        bus.req_write_i  = 1'b0;
        bus.req_size_i   = 2'b10;
        bus.req_signed_i = 1'b0;
        bus.req_addr_i   = 32'h0;
        bus.req_valid_i  = 1'b1;
        rdy_pat = 8'h0; rsp_pat = 8'h0; nresp = 0;
        rsp_data[0] = 32'h0; rsp_data[1] = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rdy_pat[k] = bus.req_ready_o;
            rsp_pat[k] = bus.rsp_valid_o;
            if (bus.rsp_valid_o && nresp < 2) begin
                rsp_data[nresp] = bus.rsp_rdata_o;
                nresp++;
            end
            if (k == 5) bus.req_valid_i = 1'b0;
        end
        check("b2b_ready", {24'h0, rdy_pat}, 32'b0100_1000);
        check("b2b_rsp", {24'h0, rsp_pat}, 32'b0010_0100);
        check("b2b_data0", rsp_data[0], 32'hBEEF_0503);
        check("b2b_data1", rsp_data[1], 32'hBEEF_0503);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
